aes_block_loader: RTL and testbench

AES_BLOCK_LOADER -- requirements
Module: aes_block_loader

---
 rtl/aes_block_loader.sv | 122 ++++++++++++
 tb/tb_aes_block_loader.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_block_loader.sv
// aes_block_loader
//   Collects a byte stream into a parallel AES-128 key and plaintext block.
//   The first 16 accepted bytes fill key0..key15, the next 16 fill
//   ptext0..ptext15. The block is then held for the downstream AES stage
//   until out_ready. With key_keep set at that handshake, the next block
//   loads plaintext only and reuses the stored key.
//
// Ports
//   sys_clk, sys_rst_n    : clock, asynchronous active-low reset
//   in_data/in_valid/in_ready : byte input; a byte moves when valid && ready
//   key_keep              : sampled at the output handshake; skips the key phase
//   clear                 : synchronous abort back to FILL with byte_cnt = 0
//   key0..key15           : registered key bytes
//   ptext0..ptext15       : registered plaintext bytes
//   out_valid/out_ready   : block output; out_valid is a flop (state == HOLD)
//   byte_cnt              : index of the next byte to be accepted
//
// Handshake semantics (both sides): a transfer happens on a rising edge where
// valid and ready are both high. Ready may be asserted before valid. Valid is
// never a combinational function of ready on the same interface.
//
// The FSM state is observable directly: out_valid is exactly (state == HOLD).
module aes_block_loader (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       key_keep,
  input  logic       clear,
  output logic [7:0] key0,  key1,  key2,  key3,
  output logic [7:0] key4,  key5,  key6,  key7,
  output logic [7:0] key8,  key9,  key10, key11,
  output logic [7:0] key12, key13, key14, key15,
  output logic [7:0] ptext0,  ptext1,  ptext2,  ptext3,
  output logic [7:0] ptext4,  ptext5,  ptext6,  ptext7,
  output logic [7:0] ptext8,  ptext9,  ptext10, ptext11,
  output logic [7:0] ptext12, ptext13, ptext14, ptext15,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [5:0] byte_cnt
);

  typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_t;

  state_t     state_q, state_d;
  logic [5:0] cnt_q,   cnt_d;
  logic [7:0] key_q   [16];
  logic [7:0] key_d   [16];
  logic [7:0] ptext_q [16];
  logic [7:0] ptext_d [16];
  logic       accept;

  // in_ready is the only unregistered output; it never looks at in_valid.
  assign in_ready = (state_q == FILL) && !clear;
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    key_d   = key_q;
    ptext_d = ptext_q;

    if (clear) begin
      // Registers are left stale on purpose; only the fill position resets.
      state_d = FILL;
      cnt_d   = 6'd0;
    end else if (accept) begin
      // Bit 4 of the count selects key (0..15) versus plaintext (16..31);
      // the low four bits are the byte index within either half.
      if (cnt_q[4]) ptext_d[cnt_q[3:0]] = in_data;
      else          key_d[cnt_q[3:0]]   = in_data;
      if (cnt_q == 6'd31) begin
        state_d = HOLD;
        cnt_d   = 6'd0;
      end else begin
        cnt_d   = cnt_q + 6'd1;
      end
    end else if ((state_q == HOLD) && out_ready) begin
      state_d = FILL;
      cnt_d   = key_keep ? 6'd16 : 6'd0;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= FILL;
      cnt_q   <= 6'd0;
      for (int i = 0; i < 16; i++) begin
        key_q[i]   <= 8'h00;
        ptext_q[i] <= 8'h00;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      key_q   <= key_d;
      ptext_q <= ptext_d;
    end
  end

  assign out_valid = (state_q == HOLD);
  assign byte_cnt  = cnt_q;

  assign key0  = key_q[0];   assign key1  = key_q[1];
  assign key2  = key_q[2];   assign key3  = key_q[3];
  assign key4  = key_q[4];   assign key5  = key_q[5];
  assign key6  = key_q[6];   assign key7  = key_q[7];
  assign key8  = key_q[8];   assign key9  = key_q[9];
  assign key10 = key_q[10];  assign key11 = key_q[11];
  assign key12 = key_q[12];  assign key13 = key_q[13];
  assign key14 = key_q[14];  assign key15 = key_q[15];

  assign ptext0  = ptext_q[0];   assign ptext1  = ptext_q[1];
  assign ptext2  = ptext_q[2];   assign ptext3  = ptext_q[3];
  assign ptext4  = ptext_q[4];   assign ptext5  = ptext_q[5];
  assign ptext6  = ptext_q[6];   assign ptext7  = ptext_q[7];
  assign ptext8  = ptext_q[8];   assign ptext9  = ptext_q[9];
  assign ptext10 = ptext_q[10];  assign ptext11 = ptext_q[11];
  assign ptext12 = ptext_q[12];  assign ptext13 = ptext_q[13];
  assign ptext14 = ptext_q[14];  assign ptext15 = ptext_q[15];

endmodule

// File: tb/tb_aes_block_loader.sv
// Bench for aes_block_loader: a hand-written vector table, directed corner
// sequences and a randomized run, all checked against a reference model that
// tracks the block as two byte arrays plus a fill position.
module tb_aes_block_loader;

  logic       sys_clk;
  logic       sys_rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       key_keep;
  logic       clear;
  logic       out_valid;
  logic       out_ready;
  logic [5:0] byte_cnt;
  logic [7:0] key_w   [16];
  logic [7:0] ptext_w [16];

  int checks = 0;
  int errors = 0;

  // ---------------- clock ----------------
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  aes_block_loader dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .key_keep  (key_keep),
    .clear     (clear),
    .key0  (key_w[0]),  .key1  (key_w[1]),  .key2  (key_w[2]),  .key3  (key_w[3]),
    .key4  (key_w[4]),  .key5  (key_w[5]),  .key6  (key_w[6]),  .key7  (key_w[7]),
    .key8  (key_w[8]),  .key9  (key_w[9]),  .key10 (key_w[10]), .key11 (key_w[11]),
    .key12 (key_w[12]), .key13 (key_w[13]), .key14 (key_w[14]), .key15 (key_w[15]),
    .ptext0  (ptext_w[0]),  .ptext1  (ptext_w[1]),  .ptext2  (ptext_w[2]),  .ptext3  (ptext_w[3]),
    .ptext4  (ptext_w[4]),  .ptext5  (ptext_w[5]),  .ptext6  (ptext_w[6]),  .ptext7  (ptext_w[7]),
    .ptext8  (ptext_w[8]),  .ptext9  (ptext_w[9]),  .ptext10 (ptext_w[10]), .ptext11 (ptext_w[11]),
    .ptext12 (ptext_w[12]), .ptext13 (ptext_w[13]), .ptext14 (ptext_w[14]), .ptext15 (ptext_w[15]),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .byte_cnt  (byte_cnt)
  );

  // ---------------- reference model ----------------
  logic [7:0] m_key [16];
  logic [7:0] m_pt  [16];
  int         m_pos;   // bytes of the current block already taken (0..31)
  bit         m_hold;  // a complete block is waiting for the consumer

  task automatic model_reset();
    for (int k = 0; k < 16; k++) begin
      m_key[k] = 8'h00;
      m_pt[k]  = 8'h00;
    end
    m_pos  = 0;
    m_hold = 0;
  endtask

  task automatic model_step(input logic iv, input logic [7:0] d,
                            input logic ordy, input logic kk, input logic clr);
    if (clr) begin
      m_hold = 0;
      m_pos  = 0;
    end else if (!m_hold) begin
      if (iv) begin
        if (m_pos < 16) m_key[m_pos] = d;
        else            m_pt[m_pos - 16] = d;
        m_pos++;
        if (m_pos == 32) begin
          m_hold = 1;
          m_pos  = 0;
        end
      end
    end else if (ordy) begin
      m_hold = 0;
      m_pos  = kk ? 16 : 0;
    end
  endtask

  function automatic logic [127:0] pack8(input logic [7:0] a [16]);
    logic [127:0] v;
    for (int k = 0; k < 16; k++) v[8*k +: 8] = a[k];
    return v;
  endfunction

  function automatic logic [127:0] seq(input logic [7:0] base);
    logic [127:0] v;
    for (int k = 0; k < 16; k++) v[8*k +: 8] = base + 8'(k);
    return v;
  endfunction

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    chk("out_valid", 128'(out_valid), 128'(m_hold));
    chk("byte_cnt",  128'(byte_cnt),  128'(m_pos));
    chk("key",       pack8(key_w),    pack8(m_key));
    chk("ptext",     pack8(ptext_w),  pack8(m_pt));
  endtask

  // ---------------- driver ----------------
  // Entered just after a rising edge; drives one cycle and checks the result.
  task automatic cycle(input logic iv, input logic [7:0] d, input logic ordy,
                       input logic kk, input logic clr);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    key_keep  = kk;
    clear     = clr;
    #1;
    chk("in_ready", 128'(in_ready), 128'(!m_hold && !clr));
    model_step(iv, d, ordy, kk, clr);
    @(posedge sys_clk);
    #1;
    check_outputs();
  endtask

  task automatic idle_inputs();
    in_valid = 0; in_data = 8'h00; out_ready = 0; key_keep = 0; clear = 0;
  endtask

  task automatic stream(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, base + 8'(i), 1'b0, 1'b0, 1'b0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       iv;
    logic [7:0] d;
    logic       ordy;
    logic       kk;
    logic       clr;
    logic       e_ready;
    logic       e_valid;
    logic [5:0] e_cnt;
  } vec_t;

  vec_t tbl [8];

  initial begin
    // Fresh after reset: gaps, clear with a byte offered, overwrite, ignored out_ready.
    tbl[0] = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'd1};
    tbl[1] = '{1'b0, 8'h99, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'd1};
    tbl[2] = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'd2};
    tbl[3] = '{1'b1, 8'hEE, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0};
    tbl[4] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0};
    tbl[5] = '{1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'd1};
    tbl[6] = '{1'b1, 8'h44, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 6'd2};
    tbl[7] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 6'd2};
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [127:0] exp_v;
    idle_inputs();
    model_reset();
    sys_rst_n = 1'b0;
    #1;
    // Reset state, seen asynchronously before any clock edge.
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_byte_cnt",  128'(byte_cnt),  128'd0);
    chk("rst_key",       pack8(key_w),    128'd0);
    chk("rst_ptext",     pack8(ptext_w),  128'd0);
    chk("rst_in_ready",  128'(in_ready),  128'd1);
    #7 sys_rst_n = 1'b1;
    @(posedge sys_clk); #1;

    // Table vectors, each checked against hand constants and the model.
    for (int i = 0; i < 8; i++) begin
      in_valid = tbl[i].iv; in_data = tbl[i].d; out_ready = tbl[i].ordy;
      key_keep = tbl[i].kk; clear = tbl[i].clr;
      #1;
      chk("tbl_in_ready", 128'(in_ready), 128'(tbl[i].e_ready));
      model_step(tbl[i].iv, tbl[i].d, tbl[i].ordy, tbl[i].kk, tbl[i].clr);
      @(posedge sys_clk); #1;
      chk("tbl_out_valid", 128'(out_valid), 128'(tbl[i].e_valid));
      chk("tbl_byte_cnt",  128'(byte_cnt),  128'(tbl[i].e_cnt));
      check_outputs();
    end
    chk("tbl_key01", 128'({key_w[1], key_w[0]}), 128'(16'h4433));

    // Basic load 00..1F after a clear.
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    stream(8'h00, 31);
    chk("load_not_yet_valid", 128'(out_valid), 128'd0);
    stream(8'h1F, 1);
    chk("load_valid", 128'(out_valid), 128'd1);
    chk("load_key",   pack8(key_w),   seq(8'h00));
    chk("load_ptext", pack8(ptext_w), seq(8'h10));

    // Backpressure: held block, bytes offered but refused.
    for (int i = 0; i < 10; i++) cycle(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0, 1'b0);
    chk("bp_key",   pack8(key_w),   seq(8'h00));
    chk("bp_ptext", pack8(ptext_w), seq(8'h10));
    chk("bp_cnt",   128'(byte_cnt), 128'd0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("bp_release", 128'(out_valid), 128'd0);

    // key_keep: reload full block, then plaintext-only block A0..AF.
    stream(8'h00, 32);
    cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    chk("kk_cnt16", 128'(byte_cnt), 128'd16);
    stream(8'hA0, 15);
    chk("kk_not_yet_valid", 128'(out_valid), 128'd0);
    stream(8'hAF, 1);
    chk("kk_valid", 128'(out_valid), 128'd1);
    chk("kk_key",   pack8(key_w),   seq(8'h00));
    chk("kk_ptext", pack8(ptext_w), seq(8'hA0));
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    // Clear mid-fill after 20 bytes; the byte offered with clear is dropped.
    stream(8'hC0, 20);
    cycle(1'b1, 8'hFF, 1'b0, 1'b0, 1'b1);
    chk("clr_cnt", 128'(byte_cnt), 128'd0);
    stream(8'h40, 32);
    chk("clr_valid", 128'(out_valid), 128'd1);
    chk("clr_key",   pack8(key_w),   seq(8'h40));
    chk("clr_ptext", pack8(ptext_w), seq(8'h50));

    // clear beats the output handshake even with key_keep.
    cycle(1'b1, 8'h77, 1'b1, 1'b1, 1'b1);
    chk("clr_hs_cnt",   128'(byte_cnt),  128'd0);
    chk("clr_hs_valid", 128'(out_valid), 128'd0);

    // Asynchronous reset pulsed mid-cycle at byte_cnt = 7.
    stream(8'h60, 7);
    chk("ar_cnt7", 128'(byte_cnt), 128'd7);
    idle_inputs();
    #3 sys_rst_n = 1'b0;
    #1;
    model_reset();
    exp_v = 128'd0;
    chk("ar_key",   pack8(key_w),    exp_v);
    chk("ar_ptext", pack8(ptext_w),  exp_v);
    chk("ar_valid", 128'(out_valid), 128'd0);
    chk("ar_cnt",   128'(byte_cnt),  128'd0);
    #2 sys_rst_n = 1'b1;
    @(posedge sys_clk); #1;
    stream(8'h80, 3);
    chk("ar_resume_cnt", 128'(byte_cnt), 128'd3);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 3) != 0), 8'($urandom_range(0, 255)),
            ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 49) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
